link_ddr_upstream_tx: RTL and testbench

Transmit end of the DDR link channel. It pairs with the downstream receiver that fills an async buffer and returns toggling tokens. The block accepts core-side words through a valid/ready handshake and holds them in a 2-entry skid FIFO. Each word is serialized as two CHANNEL_WIDTH_P phases (low half, then high half) onto io_data_o. A credit counter, refilled by receiver tokens, ensures the remote buffer never overflows.

---
 rtl/link_ddr_upstream_tx.sv | 104 ++++++++++
 tb/tb_link_ddr_upstream_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/link_ddr_upstream_tx.sv
// Transmit end of the DDR link: 2-entry skid FIFO, two-phase serializer and a
// token-refilled credit counter that keeps the remote receive buffer from overflowing.
module link_ddr_upstream_tx #(
  parameter int unsigned WIDTH_P                         = 16,
  parameter int unsigned CHANNEL_WIDTH_P                 = 8,
  parameter int unsigned LG_FIFO_DEPTH_P                 = 6,
  parameter int unsigned LG_CREDIT_TO_TOKEN_DECIMATION_P = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH_P-1:0]         core_data_i,
  input  logic                       core_valid_i,
  output logic                       core_ready_o,
  output logic [CHANNEL_WIDTH_P-1:0] io_data_o,
  output logic                       io_valid_o,
  input  logic                       io_token_i,
  output logic [LG_FIFO_DEPTH_P:0]   credit_count_o,
  output logic                       credit_err_o
);

  localparam int unsigned CW = LG_FIFO_DEPTH_P + 1;
  localparam logic [CW:0] MaxCredits   = (CW+1)'(1 << LG_FIFO_DEPTH_P);
  localparam logic [CW:0] TokenCredits = (CW+1)'(1 << LG_CREDIT_TO_TOKEN_DECIMATION_P);

  typedef enum logic [1:0] {StIdle, StSendLo, StSendHi} state_e;

  state_e                     state;
  logic [WIDTH_P-1:0]         fifo_mem [2];
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 fifo_cnt;
  logic [CHANNEL_WIDTH_P-1:0] tx_hi;
  logic [CW-1:0]              credit_q;
  logic                       tok_r;
  logic                       enq;
  logic                       launch;
  logic                       tok_evt;
  logic [WIDTH_P-1:0]         head;
  logic [CW:0]                credit_sum;

  assign core_ready_o   = (fifo_cnt != 2'd2);
  assign enq            = core_valid_i && core_ready_o;
  // A new word may start in any cycle that is not the low phase of the current one.
  assign launch         = (fifo_cnt != 2'd0) && (credit_q != '0) && (state != StSendLo);
  assign tok_evt        = tok_r ^ io_token_i;
  assign head           = fifo_mem[rd_ptr];
  assign credit_count_o = credit_q;

  // One spare bit so an over-return is visible before saturation; launch needs credit > 0.
  always_comb begin
    credit_sum = {1'b0, credit_q} - {{CW{1'b0}}, launch};
    if (tok_evt) credit_sum = credit_sum + TokenCredits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
      tx_hi        <= '0;
      credit_q     <= MaxCredits[CW-1:0];
      credit_err_o <= 1'b0;
      tok_r        <= io_token_i;
      io_valid_o   <= 1'b0;
      io_data_o    <= '0;
    end else begin
      tok_r <= io_token_i;

      if (credit_sum > MaxCredits) begin
        credit_q     <= MaxCredits[CW-1:0];
        credit_err_o <= 1'b1;
      end else begin
        credit_q <= credit_sum[CW-1:0];
      end

      if (enq) begin
        fifo_mem[wr_ptr] <= core_data_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (launch) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(enq) - 2'(launch);

      case (state)
        StSendLo: begin
          io_data_o <= tx_hi;
          state     <= StSendHi;
        end
        default: begin
          if (launch) begin
            io_valid_o <= 1'b1;
            io_data_o  <= head[CHANNEL_WIDTH_P-1:0];
            tx_hi      <= head[WIDTH_P-1:CHANNEL_WIDTH_P];
            state      <= StSendLo;
          end else begin
            io_valid_o <= 1'b0;
            state      <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_ddr_upstream_tx.sv
// Bench for link_ddr_upstream_tx: accepted words feed a phase scoreboard checked by
// an independent monitor; credits are predicted from word and token counts.
module tb_link_ddr_upstream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] core_data_i;
  logic        core_valid_i;
  logic        core_ready_o;
  logic [7:0]  io_data_o;
  logic        io_valid_o;
  logic        io_token_i;
  logic [6:0]  credit_count_o;
  logic        credit_err_o;

  link_ddr_upstream_tx dut (
    .clk            (clk),
    .rst            (rst),
    .core_data_i    (core_data_i),
    .core_valid_i   (core_valid_i),
    .core_ready_o   (core_ready_o),
    .io_data_o      (io_data_o),
    .io_valid_o     (io_valid_o),
    .io_token_i     (io_token_i),
    .credit_count_o (credit_count_o),
    .credit_err_o   (credit_err_o)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         valid_cycles = 0;
  int         valid_runs   = 0;
  logic       prev_v       = 1'b0;
  bit         rand_tok     = 1'b0;
  int         acc          = 0;
  int         tok          = 0;

  function automatic void chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  // Monitor: every io phase must be the next expected byte.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (io_valid_o) begin
        valid_cycles++;
        if (!prev_v) valid_runs++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_phase: got 0x%0h, no phase expected", io_data_o);
        end else begin
          chk("io_phase", int'(io_data_o), int'(exp_q.pop_front()));
        end
      end
      prev_v = io_valid_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  // Token toggles only when the credit upper bound (at most 2 words unlaunched) stays <= 64.
  task automatic maybe_toggle();
    if (rand_tok && (acc - 8 * tok >= 10) && ($urandom_range(0, 3) == 0)) begin
      io_token_i = ~io_token_i;
      tok++;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    core_valid_i = 1'b0;
    exp_q.delete();
    wait_cycles(2);
    rst = 1'b0;
    valid_cycles = 0;
    valid_runs   = 0;
  endtask

  task automatic send(input logic [15:0] w);
    logic rdy;
    logic ok;
    ok           = 1'b0;
    core_data_i  = w;
    core_valid_i = 1'b1;
    for (int n = 0; n < 3000 && !ok; n++) begin
      rdy = core_ready_o;
      maybe_toggle();
      @(posedge clk);
      ok = rdy;
      if (ok) begin
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        acc++;
      end
      #1;
    end
    core_valid_i = 1'b0;
    chk("word_accepted", int'(ok), 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      if (exp_q.size() == 0 && !io_valid_o) break;
      tick();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst          = 1'b1;
    core_valid_i = 1'b0;
    core_data_i  = '0;
    io_token_i   = 1'b0;

    // Reset state
    do_reset();
    chk("rst_ready", int'(core_ready_o), 1);
    chk("rst_valid", int'(io_valid_o), 0);
    chk("rst_data", int'(io_data_o), 0);
    chk("rst_credit", int'(credit_count_o), 64);
    chk("rst_err", int'(credit_err_o), 0);

    // Single word
    send(16'hBEEF);
    drain();
    wait_cycles(3);
    chk("t1_valid_cycles", valid_cycles, 2);
    chk("t1_valid_runs", valid_runs, 1);
    chk("t1_credit", int'(credit_count_o), 63);

    // Back-to-back
    do_reset();
    send(16'h1122);
    send(16'h3344);
    send(16'h5566);
    chk("t2_ready_low", int'(core_ready_o), 0);
    drain();
    wait_cycles(3);
    chk("t2_valid_cycles", valid_cycles, 6);
    chk("t2_valid_runs", valid_runs, 1);
    chk("t2_credit", int'(credit_count_o), 61);

    // Credit exhaustion
    do_reset();
    for (int i = 0; i < 66; i++) send(16'($urandom));
    wait_cycles(10);
    chk("t3_credit_zero", int'(credit_count_o), 0);
    chk("t3_valid_low", int'(io_valid_o), 0);
    chk("t3_ready_low", int'(core_ready_o), 0);
    chk("t3_queued_phases", exp_q.size(), 4);
    io_token_i = ~io_token_i;
    wait_cycles(10);
    chk("t3_queue_drained", exp_q.size(), 0);
    chk("t3_credit_after", int'(credit_count_o), 6);

    // Simultaneous consume and return at credits = 10
    do_reset();
    for (int i = 0; i < 54; i++) send(16'($urandom));
    drain();
    chk("t4_credit_pre", int'(credit_count_o), 10);
    send(16'h0F0F);
    io_token_i = ~io_token_i;
    drain();
    chk("t4_credit", int'(credit_count_o), 17);
    chk("t4_err", int'(credit_err_o), 0);

    // Over-return saturates and sets the sticky error
    do_reset();
    io_token_i = ~io_token_i;
    wait_cycles(2);
    chk("t5_credit_sat", int'(credit_count_o), 64);
    chk("t5_err_set", int'(credit_err_o), 1);
    wait_cycles(5);
    chk("t5_err_sticky", int'(credit_err_o), 1);
    do_reset();
    chk("t5_err_cleared", int'(credit_err_o), 0);

    // Reset mid-word: high phase must never appear
    send(16'hA5C3);
    tick();
    chk("t6_in_lo_phase", int'(io_valid_o), 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk("t6_valid", int'(io_valid_o), 0);
    chk("t6_credit", int'(credit_count_o), 64);
    chk("t6_ready", int'(core_ready_o), 1);
    chk("t6_data", int'(io_data_o), 0);
    wait_cycles(10);

    // Randomized traffic with paced token returns
    do_reset();
    acc      = 0;
    tok      = 0;
    rand_tok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(16'($urandom));
      repeat ($urandom_range(0, 3)) begin
        maybe_toggle();
        tick();
      end
    end
    rand_tok = 1'b0;
    while (64 - acc + 8 * tok < 8) begin
      io_token_i = ~io_token_i;
      tok++;
      tick();
    end
    drain();
    wait_cycles(2);
    chk("rand_credit", int'(credit_count_o), 64 - acc + 8 * tok);
    chk("rand_err", int'(credit_err_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
